// File: rtl/gray_wr_ptr_ctrl.sv
// Write-side pointer controller for an async FIFO: binary/Gray write pointer, registered full flag.
// Optional registered occupancy output level_o is built when GRAY_WR_LEVEL_EN is defined.
module gray_wr_ptr_ctrl #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [ADDR_W:0]   wr_ptr_gray_o,
    input  logic [ADDR_W:0]   rd_ptr_gray_i,
`ifdef GRAY_WR_LEVEL_EN
    output logic [ADDR_W:0]   level_o,
`endif
    output logic              full_o
);

    logic [ADDR_W:0] wr_bin;
    logic [ADDR_W:0] wr_gray_q;
    logic            full_q;
    logic            accept;
    logic [ADDR_W:0] wr_bin_next;
    logic [ADDR_W:0] wr_gray_next;
    logic [ADDR_W:0] rd_gray_full;

    // Write enable is also gated by reset so a request during reset is dropped.
    assign accept       = wr_valid_i & ~full_q & nreset;
    assign wr_bin_next  = wr_bin + {{ADDR_W{1'b0}}, accept};
    assign wr_gray_next = wr_bin_next ^ (wr_bin_next >> 1);
    // Full when the write pointer is a whole lap ahead: top two Gray bits differ, rest equal.
    assign rd_gray_full = {~rd_ptr_gray_i[ADDR_W:ADDR_W-1], rd_ptr_gray_i[ADDR_W-2:0]};

    assign wr_ready_o    = ~full_q;
    assign wr_en_o       = accept;
    assign wr_addr_o     = wr_bin[ADDR_W-1:0];
    assign wr_ptr_gray_o = wr_gray_q;
    assign full_o        = full_q;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            wr_bin    <= '0;
            wr_gray_q <= '0;
            full_q    <= 1'b0;
        end else begin
            wr_bin    <= wr_bin_next;
            wr_gray_q <= wr_gray_next;
            full_q    <= (wr_gray_next == rd_gray_full);
        end
    end

`ifdef GRAY_WR_LEVEL_EN
    logic [ADDR_W:0] rd_bin;
    logic [ADDR_W:0] level_q;

    always_comb begin
        rd_bin = '0;
        for (int unsigned i = 0; i <= ADDR_W; i++) begin
            rd_bin[i] = ^(rd_ptr_gray_i >> i);
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            level_q <= '0;
        end else begin
            level_q <= wr_bin_next - rd_bin;
        end
    end

    assign level_o = level_q;
`endif

endmodule
